// File: rtl/if_fetch_unit_if.sv
// Fetch front-end bundle: control from hazard/branch logic, imem request/response, IF/ID presentation.
interface if_fetch_unit_if;
  logic        start_i;
  logic        PC_write_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] PC_o;
  logic [31:0] inst_o;
  logic        flush_o;

  modport master (
    input  start_i, PC_write_i, branch_i, branch_target_i, imem_data_i,
    output imem_req_o, imem_addr_o, PC_o, inst_o, flush_o
  );

  modport slave (
    output start_i, PC_write_i, branch_i, branch_target_i, imem_data_i,
    input  imem_req_o, imem_addr_o, PC_o, inst_o, flush_o
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-cycle-latency imem reads, presents PC/inst to IF/ID.
// A stall parks the in-flight instruction in a skid entry; a taken branch redirects and emits a bubble.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic           clk_i,
  input  logic           rst_i,
  if_fetch_unit_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HELD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        hold_valid;
  logic        stall;
  logic        issue;

  assign hold_valid = (state_q == HELD);
  assign stall      = ~bus.PC_write_i & ~bus.branch_i;
  // Reset gates the request so memory sees nothing while state is being cleared.
  assign issue      = bus.start_i & bus.PC_write_i & ~bus.branch_i & ~rst_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start_i) state_d = RUN;
      RUN: begin
        if (stall && pend_valid)                state_d = HELD;
        else if (!bus.start_i && !pend_valid)   state_d = IDLE;
      end
      HELD: if (bus.PC_write_i || bus.branch_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
      hold_pc    <= 32'h0;
      hold_inst  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pend_valid <= issue;
      if (issue) begin
        pend_pc <= pc_q;
        pc_q    <= pc_q + 32'd4;
      end
      if (bus.branch_i) pc_q <= bus.branch_target_i;
      if (stall && pend_valid && !hold_valid) begin
        hold_pc   <= pend_pc;
        hold_inst <= bus.imem_data_i;
      end
    end
  end

  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = pc_q;
  assign bus.flush_o     = bus.branch_i & ~rst_i;

  // Redirect cycle always shows a bubble, whatever is parked or in flight.
  always_comb begin
    bus.PC_o   = 32'h0;
    bus.inst_o = NOP_INST;
    if (!bus.branch_i) begin
      if (hold_valid) begin
        bus.PC_o   = hold_pc;
        bus.inst_o = hold_inst;
      end else if (pend_valid) begin
        bus.PC_o   = pend_pc;
        bus.inst_o = bus.imem_data_i;
      end
    end
  end

endmodule
